// File: rtl/phys_reg_free_list_ckpt.sv
// Checkpointed free list of physical register tags (circular buffer).
// Ports: CLK/RST, dequeue_*, enqueue_*, save_*, restore_*, clear_*, count, error.
module phys_reg_free_list_ckpt #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int CHECKPOINT_COLUMNS = 4,
    localparam int PHYS_REG_WIDTH    = $clog2(NUM_PHYS_REGS),
    localparam int FREE_LIST_DEPTH   = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int LOG_FREE_LIST_DEPTH = $clog2(FREE_LIST_DEPTH),
    localparam int LOG_CHECKPOINT_COLUMNS =
        (CHECKPOINT_COLUMNS > 1) ? $clog2(CHECKPOINT_COLUMNS) : 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              dequeue_valid,
    output logic                              dequeue_ready,
    output logic [PHYS_REG_WIDTH-1:0]         dequeue_tag,
    input  logic                              enqueue_valid,
    input  logic [PHYS_REG_WIDTH-1:0]         enqueue_tag,
    input  logic                              save_valid,
    output logic                              save_ready,
    output logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
    input  logic                              restore_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
    input  logic                              clear_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] clear_column,
    output logic [LOG_FREE_LIST_DEPTH:0]      count,
    output logic                              error
);

    localparam int PW  = LOG_FREE_LIST_DEPTH + 1;
    localparam int LCW = LOG_CHECKPOINT_COLUMNS;
    localparam int NC  = CHECKPOINT_COLUMNS;

    if ((FREE_LIST_DEPTH < 2) ||
        ((FREE_LIST_DEPTH & (FREE_LIST_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("FREE_LIST_DEPTH must be a power of 2");
    end

    logic [PHYS_REG_WIDTH-1:0] entry_q [FREE_LIST_DEPTH];
    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [PW-1:0]             ckpt_head_q [NC];
    logic [NC-1:0]             valid_q, valid_d;
    logic [LCW-1:0]            ckpt_tail_q, ckpt_tail_d;
    logic                      error_q, error_d;

    logic           deq_fire, enq_fire, enq_drop;
    logic           save_fire, restore_hit, clear_same;
    logic [PW-1:0]  head_after_deq;
    logic [LCW-1:0] ckpt_tail_inc;
    logic [NC-1:0]  squash;

    assign count         = tail_q - head_q;
    assign dequeue_ready = (count != '0) && !restore_valid;
    assign dequeue_tag   = entry_q[head_q[LOG_FREE_LIST_DEPTH-1:0]];
    assign save_ready    = !valid_q[ckpt_tail_q];
    assign save_column   = ckpt_tail_q;
    assign error         = error_q;

    assign deq_fire    = dequeue_valid && dequeue_ready;
    // Full check uses the occupancy after this cycle's dequeue.
    assign enq_drop    = enqueue_valid && (count == PW'(FREE_LIST_DEPTH)) && !deq_fire;
    assign enq_fire    = enqueue_valid && !enq_drop;
    assign restore_hit = restore_valid && valid_q[restore_column];
    assign save_fire   = save_valid && save_ready && !restore_valid;
    assign clear_same  = restore_valid && (clear_column == restore_column);

    assign head_after_deq = head_q + PW'(deq_fire);
    assign ckpt_tail_inc  = (ckpt_tail_q == LCW'(NC - 1)) ? '0 : ckpt_tail_q + LCW'(1);

    // Columns from the restored one up to ckpt_tail-1, circularly.
    // A distance of zero to the tail means every column is in use.
    always_comb begin
        int dt;
        int dj;
        squash = '0;
        dt = (int'(ckpt_tail_q) - int'(restore_column) + NC) % NC;
        for (int j = 0; j < NC; j++) begin
            dj = (j - int'(restore_column) + NC) % NC;
            squash[j] = (dt == 0) || (dj < dt);
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q + PW'(enq_fire);
        valid_d     = valid_q;
        ckpt_tail_d = ckpt_tail_q;
        error_d     = error_q;

        if (restore_hit) begin
            head_d = ckpt_head_q[restore_column];
        end else if (deq_fire) begin
            head_d = head_q + PW'(1);
        end

        if (clear_valid && !clear_same) begin
            valid_d[clear_column] = 1'b0;
        end
        if (restore_hit) begin
            valid_d     = valid_d & ~squash;
            ckpt_tail_d = restore_column;
        end else if (save_fire) begin
            valid_d[ckpt_tail_q] = 1'b1;
            ckpt_tail_d          = ckpt_tail_inc;
        end

        if (enq_drop ||
            (save_valid && !save_ready) ||
            (restore_valid && !valid_q[restore_column]) ||
            (clear_valid && !clear_same && !valid_q[clear_column])) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                entry_q[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
            end
            for (int k = 0; k < NC; k++) begin
                ckpt_head_q[k] <= '0;
            end
            head_q      <= '0;
            tail_q      <= PW'(FREE_LIST_DEPTH);
            valid_q     <= '0;
            ckpt_tail_q <= '0;
            error_q     <= 1'b0;
        end else begin
            if (enq_fire) begin
                entry_q[tail_q[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_tag;
            end
            // The snapshot excludes the instruction dequeuing this cycle.
            if (save_fire) begin
                ckpt_head_q[ckpt_tail_q] <= head_after_deq;
            end
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            ckpt_tail_q <= ckpt_tail_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Testbench for phys_reg_free_list_ckpt: directed vector table plus
// randomized traffic checked against a queue-based free-list model.
module tb_phys_reg_free_list_ckpt;

    localparam int NC    = 4;
    localparam int DEPTH = 32;

    localparam int D = 1;
    localparam int E = 2;
    localparam int S = 4;
    localparam int R = 8;
    localparam int C = 16;
    localparam int X = 32;

    logic       CLK = 1'b0;
    logic       RST;
    logic       dequeue_valid;
    logic       dequeue_ready;
    logic [5:0] dequeue_tag;
    logic       enqueue_valid;
    logic [5:0] enqueue_tag;
    logic       save_valid;
    logic       save_ready;
    logic [1:0] save_column;
    logic       restore_valid;
    logic [1:0] restore_column;
    logic       clear_valid;
    logic [1:0] clear_column;
    logic [5:0] count;
    logic       error;

    always #5 CLK = ~CLK;

    phys_reg_free_list_ckpt dut (
        .CLK            (CLK),
        .RST            (RST),
        .dequeue_valid  (dequeue_valid),
        .dequeue_ready  (dequeue_ready),
        .dequeue_tag    (dequeue_tag),
        .enqueue_valid  (enqueue_valid),
        .enqueue_tag    (enqueue_tag),
        .save_valid     (save_valid),
        .save_ready     (save_ready),
        .save_column    (save_column),
        .restore_valid  (restore_valid),
        .restore_column (restore_column),
        .clear_valid    (clear_valid),
        .clear_column   (clear_column),
        .count          (count),
        .error          (error)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int op; int et; int rc; int cc;
        int rdy; int tg; int cnt; int sr; int sc; int er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int op, input int et, input int rc,
                                input int cc, input int rdy, input int tg,
                                input int cnt, input int sr, input int sc,
                                input int er);
        vec_t v;
        v.op = op;  v.et = et;   v.rc = rc;   v.cc = cc;
        v.rdy = rdy; v.tg = tg;  v.cnt = cnt; v.sr = sr;
        v.sc = sc;  v.er = er;
        tbl.push_back(v);
    endfunction

    task automatic drive(input int op, input int et, input int rc, input int cc);
        logic [5:0] t;
        logic [1:0] r;
        logic [1:0] c;
        t = et[5:0];
        r = rc[1:0];
        c = cc[1:0];
        RST            = (op & X) != 0;
        dequeue_valid  = (op & D) != 0;
        enqueue_valid  = (op & E) != 0;
        save_valid     = (op & S) != 0;
        restore_valid  = (op & R) != 0;
        clear_valid    = (op & C) != 0;
        enqueue_tag    = t;
        restore_column = r;
        clear_column   = c;
    endtask

    // Reference model: ordered free queue, a log of dequeued tags,
    // checkpoints remembered as positions in that log.
    int fl[$];
    int lg_tag[$];
    bit lg_free[$];
    bit mv[NC];
    int cpos[NC];
    int cseq[NC];
    int seqn;
    int ctail;
    bit merr;

    task automatic model_reset();
        fl.delete();
        lg_tag.delete();
        lg_free.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
        for (int k = 0; k < NC; k++) begin
            mv[k] = 0; cpos[k] = 0; cseq[k] = 0;
        end
        seqn = 0; ctail = 0; merr = 0;
    endtask

    task automatic model_step(input int op, input int et, input int rc,
                              input int cc, input int eidx);
        bit mv0[NC];
        bit rv;
        int p;
        int s;
        rv = (op & R) != 0;
        for (int k = 0; k < NC; k++) mv0[k] = mv[k];
        if ((op & D) != 0 && fl.size() > 0 && !rv) begin
            lg_tag.push_back(fl.pop_front());
            lg_free.push_back(1'b0);
        end
        if ((op & E) != 0) begin
            if (fl.size() == DEPTH) merr = 1;
            else begin
                fl.push_back(et);
                if (eidx >= 0) lg_free[eidx] = 1'b1;
            end
        end
        if ((op & S) != 0 && mv0[ctail]) merr = 1;
        if ((op & C) != 0 && !(rv && cc == rc)) begin
            if (!mv0[cc]) merr = 1;
            else mv[cc] = 0;
        end
        if (rv) begin
            if (!mv0[rc]) merr = 1;
            else begin
                p = cpos[rc];
                while (lg_tag.size() > p) begin
                    fl.push_front(lg_tag.pop_back());
                    void'(lg_free.pop_back());
                end
                s = cseq[rc];
                for (int k = 0; k < NC; k++)
                    if (mv[k] && cseq[k] >= s) mv[k] = 0;
                ctail = rc;
            end
        end else if ((op & S) != 0 && !mv0[ctail]) begin
            mv[ctail]   = 1;
            cpos[ctail] = lg_tag.size();
            cseq[ctail] = seqn;
            seqn++;
            ctail = (ctail + 1) % NC;
        end
    endtask

    initial begin
        int op, et, rc, cc, eidx, lim, any;
        int cand[$];

        drive(X, 0, 0, 0);

        // Reset then drain, stall, wrap-around refill.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            add(D, 0, 0, 0, 1, 32 + i, 32 - i, 1, 0, 0);
        add(D, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(E, 5, 0, 0, 0, 0, 0, 1, 0, 0);
        add(E, 6, 0, 0, 1, 5, 1, 1, 0, 0);
        add(E, 7, 0, 0, 1, 5, 2, 1, 0, 0);
        add(D, 0, 0, 0, 1, 5, 3, 1, 0, 0);
        add(D, 0, 0, 0, 1, 6, 2, 1, 0, 0);
        add(D, 0, 0, 0, 1, 7, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Checkpoint restore, then restore of a squashed column.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 0, 0);
        add(D, 0, 0, 0, 1, 32, 32, 1, 0, 0);
        add(D, 0, 0, 0, 1, 33, 31, 1, 0, 0);
        add(S, 0, 0, 0, 1, 34, 30, 1, 0, 0);
        add(D, 0, 0, 0, 1, 34, 30, 1, 1, 0);
        add(D, 0, 0, 0, 1, 35, 29, 1, 1, 0);
        add(D, 0, 0, 0, 1, 36, 28, 1, 1, 0);
        add(S, 0, 0, 0, 1, 37, 27, 1, 1, 0);
        add(D, 0, 0, 0, 1, 37, 27, 1, 2, 0);
        add(D | R, 0, 0, 0, 0, 0, 26, 1, 2, 0);
        add(0, 0, 0, 0, 1, 34, 30, 1, 0, 0);
        add(R, 0, 1, 0, 0, 0, 30, 1, 0, 0);
        add(0, 0, 0, 0, 1, 34, 30, 1, 0, 1);

        // Checkpoint table full, clear a non-tail column, restore.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 0, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 1, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 2, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 3, 0);
        add(0, 0, 0, 0, 1, 32, 32, 0, 0, 0);
        add(C, 0, 0, 1, 1, 32, 32, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 0, 0, 0);
        add(D | R, 0, 2, 0, 0, 0, 32, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 2, 0);
        add(C, 0, 0, 0, 1, 32, 32, 1, 2, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 2, 0);

        // Simultaneous dequeue/save/enqueue, restore, enqueue at full.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(D | S | E, 9, 0, 0, 1, 32, 32, 1, 0, 0);
        add(D, 0, 0, 0, 1, 33, 32, 1, 1, 0);
        add(D, 0, 0, 0, 1, 34, 31, 1, 1, 0);
        add(D | R, 0, 0, 0, 0, 0, 30, 1, 1, 0);
        add(E, 3, 0, 0, 1, 33, 32, 1, 0, 0);
        add(0, 0, 0, 0, 1, 33, 32, 1, 0, 1);
        add(X | D | S | E, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 0, 0);

        // Save while full of checkpoints.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 0, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 1, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 2, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 3, 0);
        add(S, 0, 0, 0, 1, 32, 32, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 0, 0, 1);

        // Clear of an invalid column.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(C, 0, 0, 2, 1, 32, 32, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 0, 1);

        // Clear and restore of the same column together.
        add(X, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(S, 0, 0, 0, 1, 32, 32, 1, 0, 0);
        add(R | C, 0, 0, 0, 0, 0, 32, 1, 1, 0);
        add(0, 0, 0, 0, 1, 32, 32, 1, 0, 0);

        foreach (tbl[k]) begin
            @(negedge CLK);
            drive(tbl[k].op, tbl[k].et, tbl[k].rc, tbl[k].cc);
            #1;
            if ((tbl[k].op & X) == 0) begin
                chk($sformatf("v%0d.rdy", k), dequeue_ready, tbl[k].rdy);
                if (tbl[k].rdy != 0)
                    chk($sformatf("v%0d.tag", k), dequeue_tag, tbl[k].tg);
                chk($sformatf("v%0d.cnt", k), count, tbl[k].cnt);
                chk($sformatf("v%0d.srdy", k), save_ready, tbl[k].sr);
                chk($sformatf("v%0d.scol", k), save_column, tbl[k].sc);
                chk($sformatf("v%0d.err", k), error, tbl[k].er);
            end
        end

        // Randomized legal traffic against the model.
        @(negedge CLK);
        drive(X, 0, 0, 0);
        model_reset();
        for (int cy = 0; cy < 3000; cy++) begin
            @(negedge CLK);
            op = 0; et = 0; rc = 0; cc = 0; eidx = -1;
            any = 0;
            for (int k = 0; k < NC; k++) if (mv[k]) any = 1;
            if (any != 0 && $urandom_range(0, 15) == 0) begin
                op |= R;
                for (int t = 0; t < 64; t++) begin
                    rc = int'($urandom_range(0, NC - 1));
                    if (mv[rc]) break;
                end
                if (!mv[rc]) op &= ~R;
            end
            if ($urandom_range(0, 1) == 1) op |= D;
            if ((op & R) == 0 && !mv[ctail] && $urandom_range(0, 3) == 0)
                op |= S;
            if (any != 0 && $urandom_range(0, 9) == 0) begin
                cc = int'($urandom_range(0, NC - 1));
                if (mv[cc]) op |= C;
            end
            lim = lg_tag.size();
            for (int k = 0; k < NC; k++)
                if (mv[k] && cpos[k] < lim) lim = cpos[k];
            cand.delete();
            for (int i = 0; i < lim; i++)
                if (!lg_free[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                op |= E;
                eidx = cand[$urandom_range(0, cand.size() - 1)];
                et = lg_tag[eidx];
            end
            drive(op, et, rc, cc);
            #1;
            chk($sformatf("r%0d.cnt", cy), count, fl.size());
            chk($sformatf("r%0d.rdy", cy), dequeue_ready,
                (fl.size() > 0 && (op & R) == 0) ? 1 : 0);
            if (fl.size() > 0)
                chk($sformatf("r%0d.tag", cy), dequeue_tag, fl[0]);
            chk($sformatf("r%0d.srdy", cy), save_ready, mv[ctail] ? 0 : 1);
            chk($sformatf("r%0d.scol", cy), save_column, ctail);
            chk($sformatf("r%0d.err", cy), error, int'(merr));
            model_step(op, et, rc, cc, eidx);
        end

        @(negedge CLK);
        drive(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
